// File: rtl/reaction_timer.sv
// Reaction-time experiment controller: random pre-stimulus wait, then BCD millisecond count.
// Define BUTTON_DEBOUNCE_EN to add a DEBOUNCE_MS stable-level filter on both buttons.
module reaction_timer #(
    parameter int unsigned MIN_DELAY   = 1024,
    parameter int unsigned RAND_BITS   = 11,
    parameter int unsigned DEBOUNCE_MS = 20
) (
    input  logic        clk_1k,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    output logic [15:0] qout,
    output logic [1:0]  flag
);

    localparam int unsigned CW = $clog2(MIN_DELAY + (1 << RAND_BITS));

    typedef enum logic [2:0] {StIdle, StWait, StLight, StShow, StFault} state_t;

    state_t        state;
    logic [15:0]   lfsr;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] load_val;

    // Index 0 is start, index 1 is stop.
    logic [1:0] btn_raw, sync1, sync2, lvl, lvl_q, btn_p;
    logic       start_p, stop_p;

    assign btn_raw = {stop, start};
    assign start_p = btn_p[0];
    assign stop_p  = btn_p[1];

    always_ff @(posedge clk_1k) begin
        if (reset) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
            lvl_q <= 2'b00;
            btn_p <= 2'b00;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            lvl_q <= lvl;
            btn_p <= lvl & ~lvl_q;
        end
    end

`ifdef BUTTON_DEBOUNCE_EN
    localparam int unsigned DBW = $clog2(DEBOUNCE_MS + 1);

    logic [1:0]     db;
    logic [DBW-1:0] db_cnt [2];

    // The debounced level follows the synchronized level only after it has disagreed
    // for DEBOUNCE_MS consecutive cycles.
    always_ff @(posedge clk_1k) begin
        if (reset) begin
            db <= 2'b00;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DBW'(DEBOUNCE_MS - 1)) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign lvl = db;
`else
    assign lvl = sync2;
`endif

    always_ff @(posedge clk_1k) begin
        if (reset) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign load_val = CW'(MIN_DELAY) + CW'(lfsr[RAND_BITS-1:0]);

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk_1k) begin
        if (reset) begin
            state    <= StIdle;
            flag     <= 2'd0;
            qout     <= 16'h0000;
            wait_cnt <= '0;
        end else begin
            unique case (state)
                StIdle, StShow, StFault: begin
                    if (start_p) begin
                        state    <= StWait;
                        flag     <= 2'd0;
                        qout     <= 16'h0000;
                        wait_cnt <= load_val;
                    end
                end
                StWait: begin
                    if (stop_p) begin
                        state <= StFault;
                        flag  <= 2'd2;
                        qout  <= 16'h0000;
                    end else if (wait_cnt == CW'(1)) begin
                        state <= StLight;
                        flag  <= 2'd1;
                        qout  <= 16'h0000;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                StLight: begin
                    // Stop or saturation both freeze the current count.
                    if (stop_p || qout == 16'h9999) begin
                        state <= StShow;
                        flag  <= 2'd3;
                    end else begin
                        qout <= bcd_inc(qout);
                    end
                end
                default: begin
                    state <= StIdle;
                    flag  <= 2'd0;
                end
            endcase
        end
    end

endmodule
